// File: rtl/bch_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the BCH correction/output path.
package bch_pkg;

   localparam int unsigned BCH_N_MAX = 1023;
   localparam int unsigned BCH_W     = 8;
   localparam int unsigned BCH_ERR_W = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      STREAM = 2'd2
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      for (int i = 0; i < 32; i++) begin
         if (x < v) begin
            x = x * 2;
            r = r + 1;
         end
      end
      return r;
   endfunction

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/bch_popcnt_w.sv
// Combinational popcount of one W-bit word, counting only bits whose mask bit is set.
module bch_popcnt_w
   import bch_pkg::*;
#(
   parameter int unsigned W  = BCH_W,
   parameter int unsigned CW = clog2(W + 1)
) (
   input  logic [W-1:0]  data_i,
   input  logic [W-1:0]  mask_i,
   output logic [CW-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int j = 0; j < W; j++) begin
         cnt_o = cnt_o + CW'(data_i[j] & mask_i[j]);
      end
   end

endmodule

// File: rtl/bch_corr_out.sv
// Captures a decoded BCH word, applies the correction, counts corrected bits and
// streams the codeword out in W-bit words with status on the last word.
module bch_corr_out
   import bch_pkg::*;
#(
   parameter int unsigned N_MAX = BCH_N_MAX,
   parameter int unsigned W     = BCH_W,
   parameter int unsigned ERR_W = BCH_ERR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             core_done,
   input  logic             core_success,
   input  logic [N_MAX-1:0] core_err_vec,
   input  logic [N_MAX-1:0] hard_bits,
   input  logic [9:0]       n,
   input  logic [3:0]       t,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   output logic             out_ok,
   output logic [ERR_W-1:0] out_err_cnt,
   output logic             ovf
);

   localparam int unsigned NW_MAX = ceil_div(N_MAX, W);
   localparam int unsigned EXT_W  = NW_MAX * W;
   localparam int unsigned KW     = clog2(NW_MAX + 1);
   localparam int unsigned BW     = clog2(EXT_W + 1);
   localparam int unsigned PW     = clog2(W + 1);
   localparam int unsigned NR_W   = clog2(N_MAX + 1);
   localparam int unsigned T_W    = 4;

   state_e            state_q;
   logic [N_MAX-1:0]  buf_q;
   logic [N_MAX-1:0]  ev_q;
   logic [NR_W-1:0]   n_r_q;
   logic [T_W-1:0]    t_r_q;
   logic              succ_r_q;
   logic [KW-1:0]     nw_q;
   logic [KW-1:0]     k_q;
   logic [ERR_W-1:0]  cnt_q;
   logic              ok_r_q;

   logic              in_ready_q;
   logic              out_valid_q;
   logic [W-1:0]      out_data_q;
   logic              out_last_q;
   logic              out_ok_q;
   logic [ERR_W-1:0]  out_err_cnt_q;
   logic              ovf_q;

   logic [NR_W-1:0]   n_eff_c;
   logic [EXT_W-1:0]  buf_ext_c;
   logic [EXT_W-1:0]  ev_ext_c;
   logic [BW-1:0]     base_c;
   logic [W-1:0]      mask_c;
   logic [W-1:0]      word_c;
   logic [W-1:0]      ev_word_c;
   logic [PW-1:0]     pop_c;
   logic [ERR_W-1:0]  cnt_sum_c;
   logic              last_c;
   logic              load_c;

   // Zero-length or oversize n means a full-length codeword.
   always_comb begin
      n_eff_c = NR_W'(n);
      if ((n == '0) || (32'(n) > N_MAX)) begin
         n_eff_c = NR_W'(N_MAX);
      end
   end

   // Word select shared by COUNT and STREAM; bits at or beyond n_r read as 0.
   always_comb begin
      buf_ext_c = EXT_W'(buf_q);
      ev_ext_c  = EXT_W'(ev_q);
      base_c    = BW'(k_q) * BW'(W);
      for (int j = 0; j < W; j++) begin
         mask_c[j] = (base_c + BW'(j)) < BW'(n_r_q);
      end
      word_c    = buf_ext_c[base_c +: W] & mask_c;
      ev_word_c = ev_ext_c[base_c +: W];
      cnt_sum_c = cnt_q + ERR_W'(pop_c);
      last_c    = (k_q == (nw_q - KW'(1)));
      load_c    = !out_valid_q || (out_ready && !out_last_q);
   end

   bch_popcnt_w #(
      .W  (W),
      .CW (PW)
   ) u_popcnt (
      .data_i (ev_word_c),
      .mask_i (mask_c),
      .cnt_o  (pop_c)
   );

   // Capture buffers survive reset; they are only rewritten by an accepted core_done.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == IDLE) && core_done) begin
         buf_q    <= core_success ? (hard_bits ^ core_err_vec) : hard_bits;
         ev_q     <= core_success ? core_err_vec : '0;
         n_r_q    <= n_eff_c;
         t_r_q    <= t;
         succ_r_q <= core_success;
         nw_q     <= KW'(ceil_div(32'(n_eff_c), W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         out_ok_q      <= 1'b0;
         out_err_cnt_q <= '0;
         ovf_q         <= 1'b0;
         k_q           <= '0;
         cnt_q         <= '0;
         ok_r_q        <= 1'b0;
      end else begin
         if (core_done && (state_q != IDLE)) begin
            ovf_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (core_done) begin
                  state_q    <= COUNT;
                  in_ready_q <= 1'b0;
                  k_q        <= '0;
                  cnt_q      <= '0;
               end
            end
            COUNT: begin
               cnt_q <= cnt_sum_c;
               if (last_c) begin
                  ok_r_q  <= succ_r_q && (cnt_sum_c <= ERR_W'(t_r_q));
                  k_q     <= '0;
                  state_q <= STREAM;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            STREAM: begin
               // Load the next word when the output register is empty or being drained.
               if (load_c) begin
                  out_valid_q   <= 1'b1;
                  out_data_q    <= word_c;
                  out_last_q    <= last_c;
                  out_ok_q      <= last_c && ok_r_q;
                  out_err_cnt_q <= (last_c && ok_r_q) ? cnt_q : '0;
                  if (!last_c) begin
                     k_q <= k_q + KW'(1);
                  end
               end else if (out_ready) begin
                  out_valid_q   <= 1'b0;
                  out_last_q    <= 1'b0;
                  out_ok_q      <= 1'b0;
                  out_err_cnt_q <= '0;
                  in_ready_q    <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;
   assign out_ok      = out_ok_q;
   assign out_err_cnt = out_err_cnt_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_bch_corr_out.sv
// Directed and randomized bench for bch_corr_out against a bit-level reference model.
module tb_bch_corr_out;
   import bch_pkg::*;

   localparam int unsigned NM = BCH_N_MAX;
   localparam int unsigned WW = BCH_W;
   localparam int unsigned EW = BCH_ERR_W;

   logic           clk = 1'b0;
   logic           rst;
   logic           core_done;
   logic           core_success;
   logic [NM-1:0]  core_err_vec;
   logic [NM-1:0]  hard_bits;
   logic [9:0]     n;
   logic [3:0]     t;
   logic           in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [WW-1:0]  out_data;
   logic           out_last;
   logic           out_ok;
   logic [EW-1:0]  out_err_cnt;
   logic           ovf;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WW-1:0] exp_w[$];
   int            exp_nw;
   logic          exp_ok;
   int            exp_cnt;

   always #5 clk = ~clk;

   bch_corr_out dut (
      .clk          (clk),
      .rst          (rst),
      .core_done    (core_done),
      .core_success (core_success),
      .core_err_vec (core_err_vec),
      .hard_bits    (hard_bits),
      .n            (n),
      .t            (t),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ok       (out_ok),
      .out_err_cnt  (out_err_cnt),
      .ovf          (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: corrected bit stream cut at the effective length, packed LSB-first.
   task automatic model(input logic [NM-1:0] hb, input logic [NM-1:0] ev,
                        input logic s, input int nn, input int tt);
      int ne;
      int c;
      logic [WW-1:0] w;
      ne = (nn == 0 || nn > int'(NM)) ? int'(NM) : nn;
      exp_nw = (ne + int'(WW) - 1) / int'(WW);
      exp_w.delete();
      for (int k = 0; k < exp_nw; k++) begin
         w = '0;
         for (int j = 0; j < int'(WW); j++) begin
            if (k * int'(WW) + j < ne) w[j] = hb[k*WW+j] ^ (s & ev[k*WW+j]);
         end
         exp_w.push_back(w);
      end
      c = 0;
      for (int p = 0; p < ne; p++) if (s && ev[p]) c++;
      exp_ok  = s && (c <= tt);
      exp_cnt = exp_ok ? c : 0;
   endtask

   // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
   task automatic run(input logic [NM-1:0] hb, input logic [NM-1:0] ev, input logic s,
                      input logic [9:0] nn, input logic [3:0] tt, input int rmode,
                      input bit inj, input int abort_at);
      int lat, idx, cyc, hs, lasts;
      model(hb, ev, s, int'(nn), int'(tt));
      out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      hard_bits = hb; core_err_vec = ev; core_success = s; n = nn; t = tt;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      hard_bits = ~hb; core_err_vec = ~ev; core_success = ~s; n = ~nn; t = ~tt;
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_nw + 1));
      idx = 0; cyc = 0; hs = 0; lasts = 0;
      while (idx < exp_nw && cyc < 5000) begin
         if (abort_at >= 0 && idx == abort_at) break;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (rmode == 0) chk("no_bubble", 32'(out_valid), 32'd1);
         if (out_valid) begin
            chk($sformatf("data[%0d]", idx), 32'(out_data), 32'(exp_w[idx]));
            chk($sformatf("last[%0d]", idx), 32'(out_last), 32'(idx == exp_nw - 1));
            if (idx == exp_nw - 1) begin
               chk("ok", 32'(out_ok), 32'(exp_ok));
               chk("err_cnt", 32'(out_err_cnt), 32'(exp_cnt));
            end
            if (out_ready) begin
               hs++;
               if (out_last) lasts++;
               idx++;
            end
         end
         if (inj && idx == 1) begin
            core_done = 1'b1;
            hard_bits = {$urandom(), $urandom()};
         end else begin
            core_done = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      core_done = 1'b0;
      chk("stream_budget", 32'(cyc < 5000), 32'd1);
      if (abort_at < 0) begin
         out_ready = 1'b0;
         chk("handshakes", 32'(hs), 32'(exp_nw));
         chk("last_count", 32'(lasts), 32'd1);
         chk("valid_drop", 32'(out_valid), 32'd0);
         chk("in_ready_after", 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      logic [NM-1:0] hb, ev;
      rst = 1'b1; core_done = 1'b0; core_success = 1'b0; core_err_vec = '0;
      hard_bits = '0; n = '0; t = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_ok", 32'(out_ok), 32'd0);
      chk("rst_err_cnt", 32'(out_err_cnt), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Two errors within t, corrected.
      hb = '0; ev = '0; ev[5] = 1'b1; ev[40] = 1'b1;
      run(hb, ev, 1'b1, 10'd63, 4'd2, 0, 1'b0, -1);
      // Decoder failure: data passes through uncorrected.
      run(hb, ev, 1'b0, 10'd63, 4'd2, 0, 1'b0, -1);
      // Three corrections exceed t=2.
      ev = '0; ev[0] = 1'b1; ev[1] = 1'b1; ev[2] = 1'b1;
      run(hb, ev, 1'b1, 10'd63, 4'd2, 0, 1'b0, -1);
      // Back-pressure pattern.
      ev = '0; ev[5] = 1'b1; ev[40] = 1'b1;
      run(hb, ev, 1'b1, 10'd63, 4'd2, 1, 1'b0, -1);
      chk("ovf_clear", 32'(ovf), 32'd0);
      // Overlapping core_done during STREAM.
      run(hb, ev, 1'b1, 10'd63, 4'd2, 0, 1'b1, -1);
      chk("ovf_set", 32'(ovf), 32'd1);
      // Reset in the middle of the stream.
      run(hb, ev, 1'b1, 10'd63, 4'd2, 0, 1'b0, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_ovf", 32'(ovf), 32'd0);
      out_ready = 1'b0;
      hb = '0; hb[0] = 1'b1; ev = '0;
      run(hb, ev, 1'b1, 10'd1, 4'd0, 0, 1'b0, -1);

      // Random decodes including n=0 (full length) and errors beyond n.
      for (int r = 0; r < 16; r++) begin
         int ne;
         for (int i = 0; i < int'(NM); i++) hb[i] = 1'($urandom_range(0, 1));
         ev = '0;
         ne = $urandom_range(0, 12);
         for (int i = 0; i < ne; i++) ev[$urandom_range(0, NM - 1)] = 1'b1;
         run(hb, ev, 1'($urandom_range(0, 1)),
             (r % 5 == 0) ? 10'd0 : 10'($urandom_range(1, 1023)),
             4'($urandom_range(0, 15)), (r % 2 == 0) ? 2 : 0, 1'b0, -1);
      end
      chk("ovf_final", 32'(ovf), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
